// File: rtl/regfile_pkg.sv
// Shared sizing defaults and read-response encoding for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    STALL = 2'd2
  } rd_rsp_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: write bypass, scoreboard check and registered response.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_pending,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_stall
);

  rd_rsp_e           rsp_q, rsp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_hit;
  logic              fwd_hit;

  // Writes to a hard-wired zero register are dropped, so they must never forward.
  assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
  assign fwd_hit  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && !zero_hit;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first
  // so no latch is inferred; the flops below take only non-blocking '<='.
  always_comb begin
    rsp_d  = IDLE;
    data_d = data_q;
    if (rd_en) begin
      if (reg_pending && !fwd_hit) begin
        rsp_d = STALL;
      end else begin
        rsp_d = VALID;
        if (zero_hit)     data_d = '0;
        else if (fwd_hit) data_d = wr_data;
        else              data_d = reg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q  <= IDLE;
      data_q <= '0;
    end else begin
      rsp_q  <= rsp_d;
      data_q <= data_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = (rsp_q == VALID);
  assign rd_stall = (rsp_q == STALL);

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register pending bits that stall reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int NUM_REGS = num_regs(ADDR_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                rda_en,
  input  logic [ADDR_W-1:0]   rda_addr,
  output logic [DATA_W-1:0]   rda_data,
  output logic                rda_valid,
  output logic                rda_stall,
  input  logic                rdb_en,
  input  logic [ADDR_W-1:0]   rdb_addr,
  output logic [DATA_W-1:0]   rdb_data,
  output logic                rdb_valid,
  output logic                rdb_stall,
  output logic [NUM_REGS-1:0] pending
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Lock is applied after the write so a same-cycle lock leaves the register pending.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en && !((ZERO_REG != 0) && (wr_addr == '0))) begin
      regs_d[wr_addr]    = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    if (lock_en && !((ZERO_REG != 0) && (lock_addr == '0))) begin
      pending_d[lock_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0]    = '0;
      pending_d[0] = 1'b0;
    end
  end

  // NOTE: the storage array is reset on purpose: every register must read 0 after
  // reset, which rules out mapping it onto a non-resettable RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  regfile_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rda (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rda_en),
    .rd_addr    (rda_addr),
    .reg_data   (regs_q[rda_addr]),
    .reg_pending(pending_q[rda_addr]),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_data    (rda_data),
    .rd_valid   (rda_valid),
    .rd_stall   (rda_stall)
  );

  regfile_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rdb (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rdb_en),
    .rd_addr    (rdb_addr),
    .reg_data   (regs_q[rdb_addr]),
    .reg_pending(pending_q[rdb_addr]),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_data    (rdb_data),
    .rd_valid   (rdb_valid),
    .rd_stall   (rdb_stall)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Drives two configurations (bypass/no zero reg, no bypass/zero reg) with shared stimulus
// and compares both against an architectural model of the register file.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, lock_en, rda_en, rdb_en;
  logic [1:0]  wr_addr, lock_addr, rda_addr, rdb_addr;
  logic [15:0] wr_data;

  logic [15:0] a_data [2];
  logic [15:0] b_data [2];
  logic        a_valid [2];
  logic        a_stall [2];
  logic        b_valid [2];
  logic        b_stall [2];
  logic [3:0]  pend [2];

  int n_cmp = 0;
  int n_err = 0;

  // Model: architectural state and expected outputs per configuration.
  localparam bit CFG_BYP [2] = '{1'b1, 1'b0};
  localparam bit CFG_ZR  [2] = '{1'b0, 1'b1};
  logic [15:0] m_reg  [2][4];
  logic        m_pend [2][4];
  logic [15:0] e_data  [2][2];
  logic        e_valid [2][2];
  logic        e_stall [2][2];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .ADDR_W(2), .BYPASS(1), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .rda_en(rda_en), .rda_addr(rda_addr),
    .rda_data(a_data[0]), .rda_valid(a_valid[0]), .rda_stall(a_stall[0]),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr),
    .rdb_data(b_data[0]), .rdb_valid(b_valid[0]), .rdb_stall(b_stall[0]),
    .pending(pend[0])
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(2), .BYPASS(0), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .rda_en(rda_en), .rda_addr(rda_addr),
    .rda_data(a_data[1]), .rda_valid(a_valid[1]), .rda_stall(a_stall[1]),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr),
    .rdb_data(b_data[1]), .rdb_valid(b_valid[1]), .rdb_stall(b_stall[1]),
    .pending(pend[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        m_reg[c][r]  = '0;
        m_pend[c][r] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        e_data[c][p]  = '0;
        e_valid[c][p] = 1'b0;
        e_stall[c][p] = 1'b0;
      end
    end
  endtask

  // Expected response of one read against the pre-edge state.
  task automatic model_read(input int c, input int p, input logic en, input logic [1:0] addr);
    bit zero, fwd;
    zero = CFG_ZR[c] && (addr == 2'd0);
    fwd  = CFG_BYP[c] && wr_en && (wr_addr == addr) && !zero;
    e_valid[c][p] = 1'b0;
    e_stall[c][p] = 1'b0;
    if (en) begin
      if (m_pend[c][addr] && !fwd) begin
        e_stall[c][p] = 1'b1;
      end else begin
        e_valid[c][p] = 1'b1;
        e_data[c][p]  = zero ? 16'h0 : (fwd ? wr_data : m_reg[c][addr]);
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ep;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) ep[r] = m_pend[c][r];
      check($sformatf("c%0d_a_data", c),  32'(a_data[c]),  32'(e_data[c][0]));
      check($sformatf("c%0d_a_valid", c), 32'(a_valid[c]), 32'(e_valid[c][0]));
      check($sformatf("c%0d_a_stall", c), 32'(a_stall[c]), 32'(e_stall[c][0]));
      check($sformatf("c%0d_b_data", c),  32'(b_data[c]),  32'(e_data[c][1]));
      check($sformatf("c%0d_b_valid", c), 32'(b_valid[c]), 32'(e_valid[c][1]));
      check($sformatf("c%0d_b_stall", c), 32'(b_stall[c]), 32'(e_stall[c][1]));
      check($sformatf("c%0d_pending", c), 32'(pend[c]),    32'(ep));
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check just after the edge.
  task automatic step(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                      input logic le, input logic [1:0] la,
                      input logic ae, input logic [1:0] aa,
                      input logic be, input logic [1:0] ba);
    wr_en = we; wr_addr = wa; wr_data = wd;
    lock_en = le; lock_addr = la;
    rda_en = ae; rda_addr = aa;
    rdb_en = be; rdb_addr = ba;
    for (int c = 0; c < 2; c++) begin
      model_read(c, 0, ae, aa);
      model_read(c, 1, be, ba);
      if (we && !(CFG_ZR[c] && wa == 2'd0)) begin
        m_reg[c][wa]  = wd;
        m_pend[c][wa] = 1'b0;
      end
      if (le && !(CFG_ZR[c] && la == 2'd0)) m_pend[c][la] = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    lock_en = 1'b0; lock_addr = '0;
    rda_en = 1'b0; rda_addr = '0; rdb_en = 1'b0; rdb_addr = '0;
    model_reset();
    #12;
    check("reset_pending", 32'(pend[0]), 32'h0);
    check("reset_a_valid", 32'(a_valid[0]), 32'h0);
    reset = 1'b0;
    #4;

    // Reset pulse during an active read clears outputs immediately.
    step(1'b1, 2'd1, 16'h7777, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    check("pre_reset_a_valid", 32'(a_valid[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_a_valid", 32'(a_valid[0]), 32'h0);
    check("async_reset_a_data",  32'(a_data[0]),  32'h0);
    model_reset();
    rda_en = 1'b0;
    #10 reset = 1'b0;
    idle();
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("post_reset_r3_data",  32'(a_data[0]),  32'h0);
    check("post_reset_r3_valid", 32'(a_valid[0]), 32'h1);

    // Write then read.
    step(1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0);
    check("wr_rd_r2_data", 32'(a_data[0]), 32'hBEEF);

    // Same-cycle write with both ports reading the written register.
    step(1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b1, 2'd1, 16'h1234, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd1);
    check("bypass_a",   32'(a_data[0]), 32'h1234);
    check("bypass_b",   32'(b_data[0]), 32'h1234);
    check("nobypass_a", 32'(a_data[1]), 32'hBEEF);
    check("nobypass_b", 32'(b_data[1]), 32'hBEEF);

    // Lock, stall, write clears.
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("lock_stall",   32'(a_stall[0]), 32'h1);
    check("lock_data",    32'(a_data[0]),  32'h1234);
    check("lock_pending", 32'(pend[0]),    32'b1000);
    step(1'b1, 2'd3, 16'h00AA, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("unlock_bypass_valid", 32'(a_valid[0]), 32'h1);
    check("unlock_bypass_data",  32'(a_data[0]),  32'h00AA);
    check("unlock_nobypass_stall", 32'(a_stall[1]), 32'h1);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("unlock_data",    32'(a_data[1]), 32'h00AA);
    check("unlock_pending", 32'(pend[0]),   32'h0);

    // Lock and write same register in one cycle: pending wins.
    step(1'b1, 2'd1, 16'h5555, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    check("lockwr_stall", 32'(a_stall[0]), 32'h1);
    step(1'b1, 2'd1, 16'h6666, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    check("lockwr_data", 32'(a_data[0]), 32'h6666);

    // Zero register ignores writes and locks.
    step(1'b1, 2'd0, 16'hFFFF, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0);
    check("zr_data",  32'(a_data[1]),  32'h0);
    check("zr_valid", 32'(a_valid[1]), 32'h1);
    check("zr_pend0", 32'(pend[1][0]), 32'h0);

    // Randomised traffic with address collisions made likely by the 4-entry space.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1, 0)), 2'($urandom()), 16'($urandom()),
           1'($urandom_range(4, 0) == 0), 2'($urandom()),
           1'($urandom_range(3, 0) != 0), 2'($urandom()),
           1'($urandom_range(3, 0) != 0), 2'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised, clocked register file for the microcontroller datapath, replacing the single-index, edge-enabled register block.
- Two independent synchronous read ports and one write port.
- Optional write-to-read bypass.
- Optional hard-wired zero register.
- Per-register pending (scoreboard) bits that stall reads of registers awaiting a multi-cycle result.
- Sits between the decode stage and the ALU/load unit.

Parameters:
- DATA_W, 16, data width of each register.
- ADDR_W, 2, index width; NUM_REGS = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the pre-write value.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and locks.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- wr_en, input, 1, write strobe.
- wr_addr, input, ADDR_W, write index.
- wr_data, input, DATA_W, write data.
- lock_en, input, 1, mark register lock_addr pending.
- lock_addr, input, ADDR_W, register to lock.
- rda_en, input, 1, port A read request.
- rda_addr, input, ADDR_W, port A index.
- rda_data, output, DATA_W, port A data, registered.
- rda_valid, output, 1, port A data valid, one-cycle pulse.
- rda_stall, output, 1, port A read refused (pending), one-cycle pulse.
- rdb_en, rdb_addr, rdb_data, rdb_valid, rdb_stall: port B, identical to port A.
- pending, output, NUM_REGS, current scoreboard bits.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - All registers = 0; pending = 0.
  - rd*_data = 0, rd*_valid = 0, rd*_stall = 0.
  - Reset mid-operation discards in-flight reads; nothing is flagged valid after release until a new request arrives.
- Write: on a clk edge with wr_en = 1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0, unless lock_en targets the same address in the same cycle.
- Lock: on a clk edge with lock_en = 1, pending[lock_addr] <= 1.
  - Lock and write to the same address in one cycle: the data is written and pending ends at 1 (the new producer wins).
- Read, per port, one-cycle latency. When rd*_en = 1 at edge N, the outputs at edge N+1 are:
  - If the register is effectively pending: rd*_stall = 1, rd*_valid = 0, rd*_data unchanged.
  - Otherwise: rd*_valid = 1, rd*_stall = 0, and rd*_data = the register value (or the forwarded value, see below).
- "Effectively pending" means pending[addr] = 1 and NOT (BYPASS = 1 and wr_en = 1 and wr_addr == addr).
- Forwarding and ordering:
  - BYPASS = 1 and wr_en with wr_addr == addr in the same cycle: data = wr_data.
  - BYPASS = 0: data = the old value. A same-cycle write does not clear the stall for that read.
  - A lock in the same cycle as a read does not affect that read; it takes effect from the next cycle.
- rd*_en = 0: valid = 0, stall = 0, rd*_data holds its last value. Outputs are never high-Z.
- Both ports may read the same address in the same cycle, including the address being written.
- ZERO_REG = 1:
  - Index 0 always reads 0 with valid.
  - Writes and locks to index 0 are dropped.
  - pending[0] is tied 0.
- All address arithmetic is modulo NUM_REGS; there are no out-of-range indices.
- The stall is informational: the requester re-issues the read. The block queues nothing.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - NUM_REGS derivation.
  - Read-response encoding constants: IDLE, VALID, STALL.
- Sub-module regfile_rdport, instantiated twice. It holds the read path for one port: bypass mux, pending check and output registers. The top-level holds the storage array and the scoreboard.

Test Plan:
1. Reset pulse mid-cycle during an active read -> rda_valid = 0 and rda_data = 0 immediately; reading reg 3 after release -> rda_data = 0x0000, rda_valid = 1.
2. Write 0xBEEF to reg 2, then read A on reg 2 at the next edge -> rda_data = 0xBEEF, rda_valid = 1 one cycle later.
3. Same-cycle write 0x1234 to reg 1 with port A and port B both reading reg 1:
   - BYPASS = 1 -> both ports return 0x1234.
   - BYPASS = 0 -> both ports return the old value 0xBEEF (reg 1 preloaded).
4. Lock reg 3, then read it -> rda_stall = 1, rda_valid = 0, rda_data unchanged, pending = 4'b1000. Write 0x00AA to reg 3 and re-read -> rda_valid = 1, rda_data = 0x00AA, pending = 0. With BYPASS = 1, a read issued in the write cycle also returns valid 0x00AA.
5. Lock and write reg 1 in the same cycle with 0x5555 -> pending[1] = 1 and a read stalls. A later write of 0x6666 clears the stall, and the read returns 0x6666.
6. ZERO_REG = 1: write 0xFFFF to reg 0 and lock reg 0 -> reading reg 0 gives 0x0000 with valid, and pending[0] = 0.
